// File: rtl/xnor3_response_checker_if.sv
// Stimulus/response bundle between a 3-input XNOR exerciser and the response checker.
// Optional first-failure fields exist only when XNOR3_FIRST_FAIL_EN is defined.
interface xnor3_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             sample_valid;
    logic             a;
    logic             b;
    logic             c;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       cov_map;
`ifdef XNOR3_FIRST_FAIL_EN
    logic [2:0]       first_fail_vec;
    logic [CNT_W-1:0] first_fail_idx;

    modport master (
        output start, sample_valid, a, b, c, dut_out,
        input  busy, done, pass, vec_cnt, err_cnt, cov_map,
        input  first_fail_vec, first_fail_idx
    );

    modport slave (
        input  start, sample_valid, a, b, c, dut_out,
        output busy, done, pass, vec_cnt, err_cnt, cov_map,
        output first_fail_vec, first_fail_idx
    );
`else
    modport master (
        output start, sample_valid, a, b, c, dut_out,
        input  busy, done, pass, vec_cnt, err_cnt, cov_map
    );

    modport slave (
        input  start, sample_valid, a, b, c, dut_out,
        output busy, done, pass, vec_cnt, err_cnt, cov_map
    );
`endif
endinterface

// File: rtl/xnor3_response_checker.sv
// Checks observed responses of a 3-input XNOR against the expected value, tracking
// vector/error counts and input coverage. XNOR3_FIRST_FAIL_EN adds first-mismatch capture.
module xnor3_response_checker #(
    parameter int CNT_W = 8  // must be at least 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    xnor3_response_checker_if.slave  chk
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [7:0]       COV_FULL = 8'hFF;

    function automatic logic xnor3_f(input logic a, input logic b, input logic c);
        return ~(a ^ b ^ c);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       cov_map_q, cov_map_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             pass_q,    pass_d;
    logic [2:0]       sample_idx_s;
    logic             mismatch_s;
`ifdef XNOR3_FIRST_FAIL_EN
    logic [2:0]       ff_vec_q,  ff_vec_d;
    logic [CNT_W-1:0] ff_idx_q,  ff_idx_d;
`endif

    assign sample_idx_s = {chk.a, chk.b, chk.c};
    assign mismatch_s   = (chk.dut_out != xnor3_f(chk.a, chk.b, chk.c));

    // Next-state, counter, coverage and verdict computation
    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        cov_map_d = cov_map_q;
`ifdef XNOR3_FIRST_FAIL_EN
        ff_vec_d  = ff_vec_q;
        ff_idx_d  = ff_idx_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // samples presented together with start belong to no run
                if (chk.start) begin
                    state_d   = ST_RUN;
                    vec_cnt_d = CNT_ZERO;
                    err_cnt_d = CNT_ZERO;
                    cov_map_d = 8'h00;
`ifdef XNOR3_FIRST_FAIL_EN
                    ff_vec_d  = 3'b000;
                    ff_idx_d  = CNT_ZERO;
`endif
                end else begin
                    state_d   = state_q;
                end
            end
            ST_RUN: begin
                if (chk.sample_valid) begin
                    vec_cnt_d               = sat_inc_f(vec_cnt_q);
                    cov_map_d[sample_idx_s] = 1'b1;
                    if (mismatch_s) begin
                        err_cnt_d = sat_inc_f(err_cnt_q);
`ifdef XNOR3_FIRST_FAIL_EN
                        // an empty error count means this is the run's first mismatch
                        if (err_cnt_q == CNT_ZERO) begin
                            ff_vec_d = sample_idx_s;
                            ff_idx_d = vec_cnt_q;
                        end else begin
                            ff_vec_d = ff_vec_q;
                            ff_idx_d = ff_idx_q;
                        end
`endif
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if ((cov_map_d == COV_FULL) || (vec_cnt_d == CNT_MAX)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                vec_cnt_d = CNT_ZERO;
                err_cnt_d = CNT_ZERO;
                cov_map_d = 8'h00;
`ifdef XNOR3_FIRST_FAIL_EN
                ff_vec_d  = 3'b000;
                ff_idx_d  = CNT_ZERO;
`endif
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_cnt_d == CNT_ZERO) && (cov_map_d == COV_FULL);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_cnt_q <= CNT_ZERO;
            err_cnt_q <= CNT_ZERO;
            cov_map_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
`ifdef XNOR3_FIRST_FAIL_EN
            ff_vec_q  <= 3'b000;
            ff_idx_q  <= CNT_ZERO;
`endif
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            cov_map_q <= cov_map_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
`ifdef XNOR3_FIRST_FAIL_EN
            ff_vec_q  <= ff_vec_d;
            ff_idx_q  <= ff_idx_d;
`endif
        end
    end

    assign chk.busy    = busy_q;
    assign chk.done    = done_q;
    assign chk.pass    = pass_q;
    assign chk.vec_cnt = vec_cnt_q;
    assign chk.err_cnt = err_cnt_q;
    assign chk.cov_map = cov_map_q;
`ifdef XNOR3_FIRST_FAIL_EN
    assign chk.first_fail_vec = ff_vec_q;
    assign chk.first_fail_idx = ff_idx_q;
`endif

endmodule

// File: tb/tb_xnor3_response_checker.sv
// Scoreboard bench: drives identical stimulus into CNT_W=8 and CNT_W=4 checkers and
// compares each against a reference model, plus fixed-value checks at key milestones.
module tb_xnor3_response_checker;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] vec;
        logic [15:0] err;
        logic [7:0]  cov;
        logic [2:0]  ffv;
        logic [15:0] ffi;
    } model_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    model_t m8, m4;
    model_t q8[$];
    model_t q4[$];

    xnor3_response_checker_if #(.CNT_W(8)) if8 ();
    xnor3_response_checker_if #(.CNT_W(4)) if4 ();

    xnor3_response_checker #(.CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .chk(if8.slave));
    xnor3_response_checker #(.CNT_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .chk(if4.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic model_t model_next(input model_t m, input logic st, input logic sv,
                                          input logic [2:0] abc, input logic o,
                                          input logic [15:0] maxv);
        model_t r;
        logic   e;
        r = m;
        if ((m.st != 2'd1) && st) begin
            r = '0;
            r.st = 2'd1;
        end else if ((m.st == 2'd1) && sv) begin
            e = ~^abc;
            if (o != e) begin
                if (m.err == 16'd0) begin
                    r.ffv = abc;
                    r.ffi = m.vec;
                end
                if (m.err < maxv) r.err = m.err + 16'd1;
            end
            if (m.vec < maxv) r.vec = m.vec + 16'd1;
            r.cov[abc] = 1'b1;
            if ((r.cov == 8'hFF) || (r.vec == maxv)) r.st = 2'd2;
        end
        return r;
    endfunction

    task automatic check_model(input string tag, input model_t e, input logic busy,
                               input logic done, input logic pass, input logic [15:0] vec,
                               input logic [15:0] err, input logic [7:0] cov,
                               input logic [2:0] ffv, input logic [15:0] ffi);
        check_val({tag, ".busy"}, 32'(busy), 32'(e.st == 2'd1));
        check_val({tag, ".done"}, 32'(done), 32'(e.st == 2'd2));
        check_val({tag, ".pass"}, 32'(pass),
                  32'((e.st == 2'd2) && (e.err == 16'd0) && (e.cov == 8'hFF)));
        check_val({tag, ".vec"}, 32'(vec), 32'(e.vec));
        check_val({tag, ".err"}, 32'(err), 32'(e.err));
        check_val({tag, ".cov"}, 32'(cov), 32'(e.cov));
`ifdef XNOR3_FIRST_FAIL_EN
        check_val({tag, ".ffv"}, 32'(ffv), 32'(e.ffv));
        check_val({tag, ".ffi"}, 32'(ffi), 32'(e.ffi));
`else
        if (ffv !== 3'b000 || ffi !== 16'd0) $display("note: unused first-fail args");
`endif
    endtask

    task automatic set_inputs(input logic st, input logic sv, input logic [2:0] abc, input logic o);
        if8.start = st; if8.sample_valid = sv; {if8.a, if8.b, if8.c} = abc; if8.dut_out = o;
        if4.start = st; if4.sample_valid = sv; {if4.a, if4.b, if4.c} = abc; if4.dut_out = o;
    endtask

    // One clock of stimulus; expectations queued at drive time, compared after the edge.
    task automatic cycle(input logic st, input logic sv, input logic [2:0] abc, input logic o);
        model_t e8, e4;
        set_inputs(st, sv, abc, o);
        m8 = model_next(m8, st, sv, abc, o, 16'd255);
        m4 = model_next(m4, st, sv, abc, o, 16'd15);
        q8.push_back(m8);
        q4.push_back(m4);
        @(posedge clk);
        #1;
        set_inputs(1'b0, 1'b0, 3'b000, 1'b0);
        e8 = q8.pop_front();
        e4 = q4.pop_front();
`ifdef XNOR3_FIRST_FAIL_EN
        check_model("d8", e8, if8.busy, if8.done, if8.pass, 16'(if8.vec_cnt), 16'(if8.err_cnt),
                    if8.cov_map, if8.first_fail_vec, 16'(if8.first_fail_idx));
        check_model("d4", e4, if4.busy, if4.done, if4.pass, 16'(if4.vec_cnt), 16'(if4.err_cnt),
                    if4.cov_map, if4.first_fail_vec, 16'(if4.first_fail_idx));
`else
        check_model("d8", e8, if8.busy, if8.done, if8.pass, 16'(if8.vec_cnt), 16'(if8.err_cnt),
                    if8.cov_map, 3'b000, 16'd0);
        check_model("d4", e4, if4.busy, if4.done, if4.pass, 16'(if4.vec_cnt), 16'(if4.err_cnt),
                    if4.cov_map, 3'b000, 16'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".d8"}, {if8.busy, if8.done, if8.pass, if8.vec_cnt, if8.err_cnt, if8.cov_map}, 32'd0);
        check_val({tag, ".d4"}, {if4.busy, if4.done, if4.pass, if4.vec_cnt, if4.err_cnt, if4.cov_map}, 32'd0);
    endtask

    task automatic sweep(input logic [2:0] bad_vec, input logic inject);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            cycle(1'b0, 1'b1, v, (~^v) ^ (inject && (v == bad_vec)));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m8 = '0;
        m4 = '0;
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // stays idle, ignores samples without start
        cycle(1'b0, 1'b1, 3'b000, 1'b1);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);

        // start with coincident sample: sample not counted
        cycle(1'b1, 1'b1, 3'b000, 1'b1);
        check_val("start_sv.vec", 32'(if8.vec_cnt), 32'd0);
        check_val("start_sv.busy", 32'(if8.busy), 32'd1);

        // clean sweep with a start pulse in the middle that must be ignored
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'(i), ~^(3'(i)));
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        check_val("run_start.vec", 32'(if8.vec_cnt), 32'd4);
        for (int i = 4; i < 8; i++) cycle(1'b0, 1'b1, 3'(i), ~^(3'(i)));
        check_val("sweep.done", 32'(if8.done), 32'd1);
        check_val("sweep.pass", 32'(if8.pass), 32'd1);
        check_val("sweep.vec", 32'(if8.vec_cnt), 32'd8);
        check_val("sweep.err", 32'(if8.err_cnt), 32'd0);
        check_val("sweep.cov", 32'(if8.cov_map), 32'hFF);

        // DONE holds and ignores samples
        cycle(1'b0, 1'b1, 3'b001, 1'b1);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);

        // sweep with 011 answered wrong
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        sweep(3'b011, 1'b1);
        check_val("bad011.done", 32'(if8.done), 32'd1);
        check_val("bad011.pass", 32'(if8.pass), 32'd0);
        check_val("bad011.err", 32'(if8.err_cnt), 32'd1);
`ifdef XNOR3_FIRST_FAIL_EN
        check_val("bad011.ffv", 32'(if8.first_fail_vec), 32'd3);
        check_val("bad011.ffi", 32'(if8.first_fail_idx), 32'd3);
`endif

        // 20 samples of 000: narrow counter saturates and finishes, wide one keeps running
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 3'b000, 1'b1);
        check_val("sat4.done", 32'(if4.done), 32'd1);
        check_val("sat4.vec", 32'(if4.vec_cnt), 32'd15);
        check_val("sat4.pass", 32'(if4.pass), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'b000, 1'b1);
        check_val("run20.busy", 32'(if8.busy), 32'd1);
        check_val("run20.done", 32'(if8.done), 32'd0);
        check_val("run20.vec", 32'(if8.vec_cnt), 32'd20);
        check_val("run20.cov", 32'(if8.cov_map), 32'h01);
        check_val("run20.d4vec", 32'(if4.vec_cnt), 32'd15);

        // reset mid-run aborts, then a fresh sweep passes
        rst_n = 1'b0;
        #2;
        check_all_zero("midrst");
        m8 = '0;
        m4 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'(i), ~^(3'(i)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        m8 = '0;
        m4 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 3'b101, 1'b1);
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        sweep(3'b000, 1'b0);
        check_val("rerun.pass8", 32'(if8.pass), 32'd1);
        check_val("rerun.pass4", 32'(if4.pass), 32'd1);

        // error counter saturation on the narrow instance
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 3'b000, 1'b0);
        check_val("errsat.err4", 32'(if4.err_cnt), 32'd15);
        check_val("errsat.err8", 32'(if8.err_cnt), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xnor3_response_checker.md
XNOR3_RESPONSE_CHECKER -- requirements
Module: xnor3_response_checker

Interface
REQ-001 Parameter CNT_W, default 8, width of the vector and error counters (minimum 4).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a check run.
REQ-005 sample_valid  input  1  a, b, c, dut_out form a valid observation this cycle.
REQ-006 a, b, c  input  1 each  stimulus bits applied to the 3-input XNOR under test.
REQ-007 dut_out  input  1  response observed from the 3-input XNOR under test.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  high while in DONE.
REQ-010 pass  output  1  run verdict, valid while done=1.
REQ-011 vec_cnt  output  CNT_W  number of samples accepted this run.
REQ-012 err_cnt  output  CNT_W  number of mismatching samples this run.
REQ-013 cov_map  output  8  bit {a,b,c} is set once that input combination has been sampled.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE->RUN on start=1; the transition SHALL clear vec_cnt, err_cnt and cov_map.
REQ-016 DONE->RUN on start=1, with the same clearing; otherwise DONE SHALL hold and freeze all outputs.
REQ-017 start in RUN SHALL be ignored.
REQ-018 sample_valid outside RUN SHALL be ignored, including the cycle in which start is accepted.
REQ-019 In RUN, on sample_valid: expected = NOT(a XOR b XOR c); vec_cnt increments; err_cnt increments if dut_out != expected; cov_map[{a,b,c}] is set.
REQ-020 vec_cnt and err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 RUN->DONE at the edge where the accepted sample makes cov_map = 8'hFF, or makes vec_cnt reach 2^CNT_W-1, whichever happens first.
REQ-022 All outputs SHALL be registered; counters, cov_map and state SHALL reflect a sample one cycle after the edge where it is accepted.
REQ-023 pass = 1 only in DONE with err_cnt = 0 and cov_map = 8'hFF; pass = 0 in all other states.

Reset
REQ-024 While rst_n=0: state = IDLE; busy, done and pass = 0; vec_cnt, err_cnt and cov_map = 0.
REQ-025 Reset asserted mid-run SHALL abort the run immediately; no partial verdict is retained.
REQ-026 After reset release, the block SHALL stay in IDLE until start.

Configuration
REQ-027 Macro XNOR3_FIRST_FAIL_EN SHALL add the outputs first_fail_vec (3 bits, the {a,b,c} of the first mismatch) and first_fail_idx (CNT_W bits, the vec_cnt value before that sample).
REQ-028 With XNOR3_FIRST_FAIL_EN defined, both outputs SHALL reset to 0, clear on run start, and be captured only on the first mismatch of the run.
REQ-029 Without XNOR3_FIRST_FAIL_EN, those ports and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-030 start, then 8 samples 000..111 with a correct dut_out -> one cycle after the 8th sample: done=1, pass=1, vec_cnt=8, err_cnt=0, cov_map=8'hFF.
REQ-031 Same sequence with dut_out inverted on 011 -> done=1, pass=0, err_cnt=1; with the macro defined, first_fail_vec=3'b011 and first_fail_idx=3.
REQ-032 start, then 20 correct samples of 000 -> busy=1, done=0, vec_cnt=20, cov_map=8'h01.
REQ-033 CNT_W=4, 15 correct samples using only 000/001 -> done after the 15th sample, vec_cnt=15, pass=0.
REQ-034 rst_n pulsed low after 5 samples -> all outputs 0 and state IDLE; a new start plus a full 8-vector sweep -> pass=1.
REQ-035 start coincident with sample_valid in IDLE -> vec_cnt=0 on the next cycle; start pulsed in RUN -> counters unchanged.
